// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner: syncs, debounces and edge-detects two coin sensors, queues coins for the vending FSM.
// Define COIN_TOTAL_EN to add the total_value running-sum output.
module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic coin5_raw,
  input  logic coin10_raw,
  input  logic accept_en,
  output logic [1:0] coin_code,
  output logic [$clog2(FIFO_DEPTH):0] queue_cnt,
  output logic overflow
`ifdef COIN_TOTAL_EN
  ,
  output logic [15:0] total_value
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  logic [1:0] s1, s2, stable, stable_d, rise, push_code;
  logic [CNT_W-1:0] cnt [2];
  logic [1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic pending, push, full, rd, wr;
  assign rise = stable & ~stable_d;
  // A simultaneous pair pushes the 5-unit coin first; the 10-unit one waits in pending.
  always_comb begin
    push = pending | (|rise);
    push_code = (rise[0] & ~pending) ? 2'd1 : 2'd2;
    full = queue_cnt == FULL;
    rd = accept_en & (|queue_cnt);
    wr = push & (~full | rd);
  end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= push_code;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      stable <= '0;
      stable_d <= '0;
      cnt <= '{default: '0};
      pending <= 1'b0;
      wp <= '0;
      rp <= '0;
      queue_cnt <= '0;
      overflow <= 1'b0;
      coin_code <= 2'd0;
    end else begin
      s1 <= {coin10_raw, coin5_raw};
      s2 <= s1;
      stable_d <= stable;
      for (int i = 0; i < 2; i++)
        if (s2[i] == stable[i]) cnt[i] <= '0;
        else if (cnt[i] == DB_LAST) begin
          stable[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      pending <= &rise;
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      queue_cnt <= queue_cnt + (AW+1)'(wr) - (AW+1)'(rd);
      if (push & full & ~rd) overflow <= 1'b1;
      coin_code <= rd ? mem[rp] : 2'd0;
    end
`ifdef COIN_TOTAL_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) total_value <= '0;
    else if (rd) total_value <= total_value + ((mem[rp] == 2'd1) ? 16'd5 : 16'd10);
`endif
endmodule

// File: tb/tb_coin_input_conditioner.sv
// tb_coin_input_conditioner: directed plus randomized stimulus against a queue-based coin model.
module tb_coin_input_conditioner;
  localparam int DB = 4;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1, coin5_raw = 1'b0, coin10_raw = 1'b0, accept_en = 1'b0;
  logic [1:0] coin_code;
  logic [2:0] queue_cnt;
  logic overflow;
`ifdef COIN_TOTAL_EN
  logic [15:0] total_value;
`endif
  coin_input_conditioner #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .coin5_raw(coin5_raw),
    .coin10_raw(coin10_raw),
    .accept_en(accept_en),
    .coin_code(coin_code),
    .queue_cnt(queue_cnt),
    .overflow(overflow)
`ifdef COIN_TOTAL_EN
    ,
    .total_value(total_value)
`endif
  );
  always #5 clk = ~clk;
  int nchk = 0, npass = 0, nfail = 0, ncyc = 0;
  int obs[$], cyc[$];
  // reference model: raw samples age two cycles, a level is accepted after DB differing
  // samples in a row, each accepted rise waits one cycle, then goes through a bounded queue
  int fifo[$], pend[$], dly5[$], dly10[$];
  int st5, st10, run5, run10, m_code, m_ovf, m_total;
  task automatic chk(input string tag, input int o, input int e);
    nchk++;
    assert (o === e) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0d, expected %0d", tag, o, e);
    end
  endtask
  function automatic void deb(input int s, inout int st, inout int run, output bit r);
    r = 1'b0;
    if (s != st) begin
      run++;
      if (run == DB) begin
        st = s;
        run = 0;
        r = (s == 1);
      end
    end else run = 0;
  endfunction
  task automatic model_reset();
    fifo = {};
    pend = {};
    dly5 = '{0, 0};
    dly10 = '{0, 0};
    st5 = 0; st10 = 0; run5 = 0; run10 = 0;
    m_code = 0; m_ovf = 0; m_total = 0;
  endtask
  task automatic model_step(input int c5, input int c10, input int acc);
    int code, s5, s10;
    bit rd, full, r5, r10;
    code = (pend.size() > 0) ? pend.pop_front() : 0;
    full = fifo.size() == DEPTH;
    rd = acc != 0 && fifo.size() > 0;
    m_code = rd ? fifo.pop_front() : 0;
    m_total = (m_total + (m_code == 1 ? 5 : m_code == 2 ? 10 : 0)) % 65536;
    if (code != 0) begin
      if (!full || rd) fifo.push_back(code);
      else m_ovf = 1;
    end
    s5 = dly5.pop_front();
    dly5.push_back(c5);
    s10 = dly10.pop_front();
    dly10.push_back(c10);
    deb(s5, st5, run5, r5);
    deb(s10, st10, run10, r10);
    if (r5) pend.push_back(1);
    if (r10) pend.push_back(2);
  endtask
  task automatic check_model();
    chk("code", int'(coin_code), m_code);
    chk("cnt", int'(queue_cnt), fifo.size());
    chk("ovf", int'(overflow), m_ovf);
`ifdef COIN_TOTAL_EN
    chk("total", int'(total_value), m_total);
`endif
  endtask
  task automatic step(input logic c5, input logic c10, input logic acc, input int n);
    repeat (n) begin
      coin5_raw = c5;
      coin10_raw = c10;
      accept_en = acc;
      @(posedge clk);
      #1;
      model_step(int'(c5), int'(c10), int'(acc));
      check_model();
      if (coin_code != 2'd0) begin
        obs.push_back(int'(coin_code));
        cyc.push_back(ncyc);
      end
      ncyc++;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    coin5_raw = 1'b0;
    coin10_raw = 1'b0;
    accept_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_model();
  endtask
  initial begin
    int h, l, t;
    do_reset();
    chk("rst_code", int'(coin_code), 0);
    chk("rst_cnt", int'(queue_cnt), 0);
    chk("rst_ovf", int'(overflow), 0);
    // single coin: visible only after edge DB+4
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 1'b1, 1);
      chk(i == DB + 4 ? "lat_hit" : "lat_quiet", int'(coin_code), i == DB + 4 ? 1 : 0);
    end
    chk("single_cnt", int'(queue_cnt), 0);
    step(1'b0, 1'b0, 1'b1, 10);
    // bounce rejection
    obs.delete();
    t = 0;
    while (t < 20) begin
      h = $urandom_range(1, DB - 1);
      l = $urandom_range(1, 2);
      step(1'b0, 1'b1, 1'b1, h);
      step(1'b0, 1'b0, 1'b1, l);
      t += h + l;
    end
    chk("bounce_none", obs.size(), 0);
    step(1'b0, 1'b1, 1'b1, 10);
    chk("bounce_one", obs.size(), 1);
    if (obs.size() == 1) chk("bounce_code", obs[0], 2);
    step(1'b0, 1'b0, 1'b1, 10);
    // simultaneous coins
    obs.delete();
    cyc.delete();
    step(1'b1, 1'b1, 1'b1, 10);
    chk("simul_n", obs.size(), 2);
    if (obs.size() == 2) begin
      chk("simul_first", obs[0], 1);
      chk("simul_second", obs[1], 2);
      chk("simul_gap", cyc[1] - cyc[0], 1);
    end
    step(1'b0, 1'b0, 1'b1, 10);
    // backpressure and overflow
    repeat (5) begin
      step(1'b1, 1'b0, 1'b0, 8);
      step(1'b0, 1'b0, 1'b0, 8);
    end
    chk("bp_cnt", int'(queue_cnt), 4);
    chk("bp_ovf", int'(overflow), 1);
    obs.delete();
    cyc.delete();
    step(1'b0, 1'b0, 1'b1, 6);
    chk("drain_n", obs.size(), 4);
    if (obs.size() == 4) begin
      foreach (obs[i]) chk("drain_code", obs[i], 1);
      chk("drain_span", cyc[3] - cyc[0], 3);
    end
    chk("drain_cnt", int'(queue_cnt), 0);
    chk("drain_ovf", int'(overflow), 1);
    // reset mid-operation, asserted between edges
    repeat (3) begin
      step(1'b1, 1'b0, 1'b0, 8);
      step(1'b0, 1'b0, 1'b0, 8);
    end
    chk("mid_cnt", int'(queue_cnt), 3);
    #3 rst = 1'b1;
    model_reset();
    #1;
    chk("mid_code", int'(coin_code), 0);
    chk("mid_cnt0", int'(queue_cnt), 0);
    chk("mid_ovf", int'(overflow), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    obs.delete();
    step(1'b0, 1'b0, 1'b1, 12);
    chk("mid_none", obs.size(), 0);
`ifdef COIN_TOTAL_EN
    step(1'b1, 1'b0, 1'b1, 8);
    step(1'b0, 1'b0, 1'b1, 8);
    repeat (2) begin
      step(1'b0, 1'b1, 1'b1, 8);
      step(1'b0, 1'b0, 1'b1, 8);
    end
    chk("total_25", int'(total_value), 25);
    do_reset();
    chk("total_rst", int'(total_value), 0);
`endif
    // randomized level segments
    for (int k = 0; k < 40; k++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           $urandom_range(1, 12));
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
